mesh_link_arbiter: RTL
======================

Name: mesh_link_arbiter

Overview:
- Round-robin arbiter that shares one mesh link output among NREQ requesters: router input ports plus the local PE port.
- Each requester presents a flit with a send/ready handshake. The winner's flit is captured into a 1-deep output register, which drives the link with so/do and is drained by ro.
- Sits between the router's input buffers and the mesh_link instance on each output direction.

Parameters:
- WIDTH, 64, flit width in bits.
- NREQ, 4, number of requesters (must be ≥2).
- PW, $clog2(NREQ), round-robin pointer width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; asserted when reset==0 at a rising clk edge.
- di  input  NREQ*WIDTH  requester flits; requester i occupies di[i*WIDTH +: WIDTH].
- si  input  NREQ  requester i send/valid.
- ri  output  NREQ  ready to requester i; at most one bit high per cycle.
- do  output  WIDTH  link flit (registered).
- so  output  1  link send/valid (registered).
- ro  input  1  link ready from downstream.
- xfer_cnt  output  16  present only with MESH_ARB_CNT_EN.

Behaviour:
- Reset (reset==0 at a clk edge): so=0, do=0, rr pointer ptr=0. ri=0 while so=0 and si=0. If reset is asserted mid-transfer, the held flit is discarded; no ri pulse is issued that cycle.
- Input handshake: requester i transfers when si[i]&&ri[i] at a clk edge. A requester holds si[i] and its di slice stable until accepted; it must not depend on ri to raise si.
- Output handshake: link transfer when so&&ro at a clk edge. do and so are stable while so=1 and ro=0.
- can_load = !so || ro, combinational.
- Grant selection, combinational:
  - Search si starting at index ptr, ascending, wrapping NREQ-1 -> 0.
  - g = first set index; any_req = |si.
  - ri[g] = can_load && any_req; all other ri bits 0.
- Register update, priority order:
  - 1. If can_load && any_req: do <= di[g]; so <= 1; ptr <= (g==NREQ-1) ? 0 : g+1.
  - 2. Else if so && ro: so <= 0; do holds its last value; ptr unchanged.
  - 3. Else: hold.
- Latency: 1 cycle from input accept to so=1 with that flit.
- Throughput: 1 flit/cycle with ro held high. Simultaneous output drain and new load in the same cycle is required (no bubble).
- Backpressure: ro=0 with so=1 forces ri=0 for all requesters. The pointer does not move, so a waiting requester keeps its position.
- Fairness: with all si high and ro=1, grants rotate 0,1,…,NREQ-1,0,… Any continuously requesting port is granted within NREQ loads.
- Idle: no requests and ro=1 -> so falls to 0 one cycle after the last flit drains.
- Pointer arithmetic wraps modulo NREQ. For non-power-of-2 NREQ, ptr values ≥NREQ are unreachable.

Optional Feature:
- Macro: MESH_ARB_CNT_EN.
- Defined:
  - Port xfer_cnt[15:0] exists.
  - Reset value 0.
  - Increments by 1 on every output transfer (so&&ro).
  - Saturates at 16'hFFFF, no wrap.
  - Reset clears it.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan (NREQ=4, WIDTH=64):
- Reset: hold reset=0 for 2 cycles with si=4'b1111 -> so=0, do=0, ri=0. First edge after release: ri=4'b0001. Next cycle: do=di[0], so=1.
- Round-robin streaming: si=4'b1111, ro=1, di[i]=64'hA0+i, 8 cycles -> do sequence A0,A1,A2,A3,A0,A1,A2,A3 on consecutive cycles; so stays 1.
- Backpressure: so=1 with do=A1, ro=0 for 3 cycles, si=4'b1100 -> ri=0 and do=A1 held each cycle. First cycle ro=1: ri=4'b0100. Next cycle: do=di[2].
- Wrap/skip: ptr=3, si=4'b0011 -> grant 0, then ptr=1; next grant 1, then ptr=2. With si=4'b1000 only -> grant 3, then ptr=0.
- Drain to idle: single flit from requester 2, then si=0, ro=1 -> so=1 for exactly 1 cycle, then 0; ptr=3.
- MESH_ARB_CNT_EN: 5 transfers -> xfer_cnt=5. Force 70000 transfers -> xfer_cnt=16'hFFFF. Reset -> 0.

Source files
------------

// File: rtl/mesh_link_arbiter.sv
// Purpose: round-robin arbiter sharing one mesh link among NREQ requesters into a 1-deep output register.
// Latency: 1 cycle from input accept to so=1 carrying that flit; 1 flit/cycle sustained with ro high.
// Backpressure: ro=0 while so=1 holds do/so and forces ri=0; the rr pointer stays put so waiters keep priority.
// Optional: define MESH_ARB_CNT_EN to add the saturating xfer_cnt output-transfer counter.
// The link flit output is named do_dat because 'do' is a reserved word in SystemVerilog.
module mesh_link_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ*WIDTH-1:0] di,
  input  logic [NREQ-1:0]       si,
  output logic [NREQ-1:0]       ri,
  output logic [WIDTH-1:0]      do_dat,
  output logic                  so,
  input  logic                  ro
`ifdef MESH_ARB_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    g;
  logic             any_req;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] sel_dat;

  assign any_req  = |si;
  assign can_load = !so || ro;
  assign load     = can_load && any_req;

  // Grant search: first set si at or after ptr, wrapping; lowest offset wins.
  always_comb begin
    int idx;
    g   = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (si[idx]) g = PW'(idx);
    end
  end

  // Winner's flit slice.
  always_comb begin
    sel_dat = di[int'(g)*WIDTH +: WIDTH];
  end

  // Ready back to the winner only; suppressed while reset is asserted so no accept is implied.
  always_comb begin
    ri = '0;
    if (reset && load) ri[g] = 1'b1;
  end

  // Output register and rr pointer: load (drain-and-refill allowed) has priority over plain drain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      so     <= 1'b0;
      do_dat <= '0;
      ptr    <= '0;
    end else if (load) begin
      do_dat <= sel_dat;
      so     <= 1'b1;
      ptr    <= (g == LAST) ? '0 : g + 1'b1;
    end else if (so && ro) begin
      so <= 1'b0;
    end
  end

`ifdef MESH_ARB_CNT_EN
  // Saturating count of completed link transfers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      xfer_cnt <= '0;
    end else if (so && ro && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule
